stream_mux_arb: RTL and testbench
=================================

# stream_mux_arb

Parametrised N-to-1 registered datapath multiplexer with valid/ready handshake and built-in arbitration. It generalises the fixed 2:1 and 3:1 selectors to any channel count and data width. Selection is by internal fixed-priority or round-robin arbitration rather than an external select. It sits between multiple producers (e.g. writeback sources, memory request queues) and a single consumer, and provides one output register stage that breaks the timing path.

## Interface
Parameters:
- WIDTH, 32, data width of every channel and of the output
- N, 4, number of input channels (N ≥ 1; need not be a power of two)
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round robin
- SEL_W (localparam), max(1, clog2(N)), width of channel index

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i offers a word
- in_ready  out  N  channel i word accepted this cycle (one-hot or zero)
- out_data  out  WIDTH  registered output word
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- Output register: one entry {out_data, out_sel, out_valid}.
- load_en = !out_valid || out_ready (empty or draining this cycle); combinational path out_ready -> in_ready exists and is intended.
- grant: computed combinationally among channels with in_valid=1:
  - MODE 0: lowest asserted index.
  - MODE 1: first asserted index searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
- in_ready[i] = load_en && any(in_valid) && grant==i; never more than one bit set; in_ready[i] never asserted while in_valid[i]=0.
- Transfer on channel i: in_valid[i] && in_ready[i]. On transfer: out_data <= in_data[i], out_sel <= i, out_valid <= 1.
- If load_en and no in_valid: out_valid <= 0 (data/sel may hold old values, don't-care).
- If !load_en: register holds; out_data and out_sel stay stable while out_valid && !out_ready.
- Round-robin pointer ptr (SEL_W bits): on transfer from channel g, ptr <= g+1, wrapping N-1 -> 0. Unchanged without transfer. Unused in MODE 0.
- ptr and grant never exceed N-1 for non-power-of-two N.
- N=1: grant always 0; block reduces to a one-entry pipeline register.

## Timing
- Reset (rst_n=0 at a rising edge): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is 0 while rst_n=0.
- Reset mid-operation: a held, unconsumed word is discarded. No transfer occurs in a reset cycle.
- Latency: word accepted at edge k appears on out_data with out_valid=1 after edge k (visible in cycle k+1).
- Throughput: one word per cycle when out_ready stays 1.
- Back-pressure: the cycle after out_ready goes 0 with out_valid=1, all in_ready=0 and the output holds.
- Simultaneous drain and load in the same cycle: the new word replaces the old with no bubble.
- Producers hold in_data/in_valid until accepted; the block does not require it, but re-arbitrates every cycle.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. After release, first accept on channel 0.
- Round robin, N=4, MODE=1, all in_valid=1, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_data matching channel words, one word per cycle.
- Fixed priority, MODE=0, in_valid=4'b1010, out_ready=1 -> out_sel=1 every cycle. Channel 3 is starved.
- Back-pressure: out_valid=1 with data 0xDEADBEEF, out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0. out_ready=1 -> next word loaded the same edge.
- Wrap and non-power-of-two: N=3, MODE=1, ptr=2, in_valid=3'b011 -> grant 0, ptr becomes 1; then grant 1, ptr becomes 2. out_sel never reaches 3.
- Reset mid-operation: out_valid=1 holding a word, assert rst_n=0 one cycle -> out_valid=0, ptr=0, and the held word is never delivered.

Source files
------------

// File: rtl/stream_mux_arb.sv
// N-to-1 registered stream multiplexer with valid/ready handshake.
// Arbitration is fixed priority (MODE=0) or round robin (MODE=1) over channels with in_valid set.
module stream_mux_arb #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int MODE  = 1,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] grant;
   logic             found;
   logic             any_valid;
   logic             load_en;
   int               start;

   // Channel index offset from the search start, folded back into 0..N-1.
   function automatic int wrap_idx(input int base, input int k);
      int s;
      s = base + k;
      return (s >= N) ? s - N : s;
   endfunction

   assign any_valid = |in_valid;
   assign load_en   = !out_valid || out_ready;
   assign start     = (MODE == 1) ? int'(ptr) : 0;

   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && in_valid[wrap_idx(start, k)]) begin
            grant = SEL_W'(wrap_idx(start, k));
            found = 1'b1;
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = rst_n && load_en && any_valid && (grant == SEL_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (any_valid) begin
            out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_sel   <= grant;
            out_valid <= 1'b1;
            ptr       <= (grant == SEL_W'(N-1)) ? '0 : grant + SEL_W'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: three instances (RR N=4, FP N=4, RR N=3)
// compared every cycle against a queue-free behavioural model, plus directed scenario checks.
module tb_stream_mux_arb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0] data [3][4];
   logic [3:0]  vld  [3];
   logic        ordy [3];

   logic [3:0]  rdy_rr4, rdy_fp4;
   logic [2:0]  rdy_rr3;
   logic [3:0]  ird [3];
   logic [31:0] od  [3];
   logic [1:0]  os  [3];
   logic        ov  [3];

   assign ird[0] = rdy_rr4;
   assign ird[1] = rdy_fp4;
   assign ird[2] = {1'b0, rdy_rr3};

   stream_mux_arb #(.WIDTH(32), .N(4), .MODE(1)) u_rr4 (
      .clk(clk), .rst_n(rst_n),
      .in_data({data[0][3], data[0][2], data[0][1], data[0][0]}),
      .in_valid(vld[0]), .in_ready(rdy_rr4),
      .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0]), .out_ready(ordy[0]));

   stream_mux_arb #(.WIDTH(32), .N(4), .MODE(0)) u_fp4 (
      .clk(clk), .rst_n(rst_n),
      .in_data({data[1][3], data[1][2], data[1][1], data[1][0]}),
      .in_valid(vld[1]), .in_ready(rdy_fp4),
      .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1]), .out_ready(ordy[1]));

   stream_mux_arb #(.WIDTH(32), .N(3), .MODE(1)) u_rr3 (
      .clk(clk), .rst_n(rst_n),
      .in_data({data[2][2], data[2][1], data[2][0]}),
      .in_valid(vld[2][2:0]), .in_ready(rdy_rr3),
      .out_data(od[2]), .out_sel(os[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state: contents of the output register and the round-robin pointer.
   logic        mv [3];
   logic [31:0] md [3];
   int          ms [3];
   int          mp [3];

   function automatic int n_of(input int id);
      return (id == 2) ? 3 : 4;
   endfunction

   function automatic int mode_of(input int id);
      return (id == 1) ? 0 : 1;
   endfunction

   function automatic int model_grant(input int id);
      int n, c;
      n = n_of(id);
      for (int k = 0; k < n; k++) begin
         c = (mode_of(id) == 1) ? (mp[id] + k) % n : k;
         if (vld[id][c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int id = 0; id < 3; id++) begin
         mv[id] = 1'b0; md[id] = '0; ms[id] = 0; mp[id] = 0;
      end
   endtask

   // One clock: compare each instance at the falling edge, advance the model, then
   // return 1 time unit after the rising edge so callers can drive the next inputs.
   task automatic step();
      int         g;
      logic       load;
      logic [3:0] er;
      @(negedge clk);
      for (int id = 0; id < 3; id++) begin
         g    = model_grant(id);
         load = !mv[id] || ordy[id];
         er   = (rst_n && load && g >= 0) ? 4'(1 << g) : 4'b0;
         tests_run++;
         if (ird[id] !== er) begin
            tests_failed++;
            $display("FAIL in_ready[%0d] t=%0t: got %b expected %b", id, $time, ird[id], er);
         end
         tests_run++;
         if (ov[id] !== mv[id]) begin
            tests_failed++;
            $display("FAIL out_valid[%0d] t=%0t: got %b expected %b", id, $time, ov[id], mv[id]);
         end
         if (mv[id]) begin
            tests_run++;
            if (od[id] !== md[id] || os[id] !== 2'(ms[id])) begin
               tests_failed++;
               $display("FAIL out_word[%0d] t=%0t: got data %h sel %0d expected data %h sel %0d",
                        id, $time, od[id], os[id], md[id], ms[id]);
            end
         end
         if (!rst_n) begin
            mv[id] = 1'b0; md[id] = '0; ms[id] = 0; mp[id] = 0;
         end else if (load) begin
            if (g >= 0) begin
               mv[id] = 1'b1; md[id] = data[id][g]; ms[id] = g; mp[id] = (g + 1) % n_of(id);
            end else begin
               mv[id] = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic r);
      for (int id = 0; id < 3; id++) begin
         vld[id]  = v;
         ordy[id] = r;
      end
   endtask

   task automatic new_data();
      for (int id = 0; id < 3; id++)
         for (int c = 0; c < 4; c++)
            data[id][c] = $urandom;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(4'hF, 1'b1);
      step();
      step();
      tests_run++;
      if (ird[0] !== 4'b0 || ov[0] !== 1'b0 || od[0] !== 32'h0 || os[0] !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_state: got rdy %b valid %b data %h sel %0d expected 0 0 0 0",
                  ird[0], ov[0], od[0], os[0]);
      end
      rst_n = 1'b1;
      step();
      tests_run++;
      if (ov[0] !== 1'b1 || os[0] !== 2'd0 || od[0] !== data[0][0]) begin
         tests_failed++;
         $display("FAIL first_accept: got valid %b sel %0d data %h expected 1 0 %h",
                  ov[0], os[0], od[0], data[0][0]);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_d;
      apply_reset();
      drive(4'hF, 1'b1);
      for (int i = 0; i < 6; i++) begin
         new_data();
         exp_d = data[0][i % 4];
         step();
         tests_run++;
         if (ov[0] !== 1'b1 || os[0] !== 2'(i % 4) || od[0] !== exp_d) begin
            tests_failed++;
            $display("FAIL rr_sequence step %0d: got sel %0d data %h expected sel %0d data %h",
                     i, os[0], od[0], i % 4, exp_d);
         end
         tests_run++;
         if (os[1] !== 2'd0) begin
            tests_failed++;
            $display("FAIL fp_all_valid: got sel %0d expected 0", os[1]);
         end
      end
   endtask

   task automatic test_fixed_priority();
      logic [31:0] exp_d;
      apply_reset();
      drive(4'b1010, 1'b1);
      for (int i = 0; i < 5; i++) begin
         new_data();
         exp_d = data[1][1];
         step();
         tests_run++;
         if (ov[1] !== 1'b1 || os[1] !== 2'd1 || od[1] !== exp_d) begin
            tests_failed++;
            $display("FAIL fp_starve step %0d: got sel %0d data %h expected sel 1 data %h",
                     i, os[1], od[1], exp_d);
         end
      end
   endtask

   task automatic test_back_pressure();
      apply_reset();
      drive(4'b0001, 1'b1);
      for (int id = 0; id < 3; id++) data[id][0] = 32'hDEADBEEF;
      step();
      drive(4'b0001, 1'b0);
      for (int id = 0; id < 3; id++) data[id][0] = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (od[0] !== 32'hDEADBEEF || os[0] !== 2'd0 || ov[0] !== 1'b1 || ird[0] !== 4'b0) begin
            tests_failed++;
            $display("FAIL back_pressure step %0d: got data %h sel %0d valid %b rdy %b expected deadbeef 0 1 0000",
                     i, od[0], os[0], ov[0], ird[0]);
         end
      end
      drive(4'b0001, 1'b1);
      step();
      tests_run++;
      if (od[0] !== 32'h1234_5678 || ov[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL drain_and_load: got data %h valid %b expected 12345678 1", od[0], ov[0]);
      end
   endtask

   task automatic test_wrap_n3();
      apply_reset();
      drive(4'b0010, 1'b1);
      step();
      drive(4'b0011, 1'b1);
      step();
      tests_run++;
      if (os[2] !== 2'd0) begin
         tests_failed++;
         $display("FAIL n3_wrap_grant0: got sel %0d expected 0", os[2]);
      end
      step();
      tests_run++;
      if (os[2] !== 2'd1) begin
         tests_failed++;
         $display("FAIL n3_wrap_grant1: got sel %0d expected 1", os[2]);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      new_data();
      drive(4'b0100, 1'b1);
      step();
      tests_run++;
      if (ov[0] !== 1'b1 || os[0] !== 2'd2) begin
         tests_failed++;
         $display("FAIL mid_load: got valid %b sel %0d expected 1 2", ov[0], os[0]);
      end
      drive(4'b0100, 1'b0);
      step();
      rst_n = 1'b0;
      drive(4'b0000, 1'b0);
      step();
      rst_n = 1'b1;
      tests_run++;
      if (ov[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_clear: got valid %b expected 0", ov[0]);
      end
      drive(4'b0000, 1'b1);
      step();
      tests_run++;
      if (ov[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL held_word_dropped: got valid %b expected 0", ov[0]);
      end
      drive(4'hF, 1'b1);
      step();
      tests_run++;
      if (os[0] !== 2'd0) begin
         tests_failed++;
         $display("FAIL ptr_after_reset: got sel %0d expected 0", os[0]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         new_data();
         for (int id = 0; id < 3; id++) begin
            vld[id]  = 4'($urandom);
            ordy[id] = ($urandom_range(0, 3) != 0);
         end
         rst_n = ($urandom_range(0, 49) != 0);
         step();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(4'hF, 1'b1);
      new_data();
      @(posedge clk);
      #1;
      model_reset();
      test_reset();
      test_round_robin();
      test_fixed_priority();
      test_back_pressure();
      test_wrap_n3();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
